// File: rtl/bfu_stage16_pkg.sv
// bfu_stage16_pkg: shared state codes, widths and saturation helper for the stage-1 SDF butterfly
package bfu_stage16_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, FIRST = 2'b01, SECOND = 2'b10, WAITING = 2'b11} state_t;
   localparam int DW_I = 8;
   localparam int DW_O = 9;
   localparam int WW = 8;
   localparam int WFRAC = 6;
   localparam int DEPTH = 16;
   localparam int IW = 5;
   localparam int PW = DW_O + WW + 1;
   localparam int RND = 1 << (WFRAC - 1);
   localparam logic signed [DW_O-1:0] SAT_MAX = {1'b0, {(DW_O-1){1'b1}}};
   localparam logic signed [DW_O-1:0] SAT_MIN = {1'b1, {(DW_O-1){1'b0}}};
   function automatic logic signed [DW_O-1:0] sat(input logic signed [PW-1:0] v);
      return (v > PW'(SAT_MAX)) ? SAT_MAX : (v < PW'(SAT_MIN)) ? SAT_MIN : v[DW_O-1:0];
   endfunction
endpackage

// File: rtl/bfu_stage16_if.sv
// bfu_stage16_if: control/sample input bus and butterfly result bus
interface bfu_stage16_if;
   import bfu_stage16_pkg::*;
   state_t                  state_i;
   logic signed [DW_I-1:0]  data_a_r, data_a_i;
   logic signed [WW-1:0]    WN_r, WN_i;
   logic                    valid_o;
   logic [IW-1:0]           out_idx;
   logic signed [DW_O-1:0]  data_out_r, data_out_i;
   modport master (output state_i, data_a_r, data_a_i, WN_r, WN_i,
                   input valid_o, out_idx, data_out_r, data_out_i);
   modport slave (input state_i, data_a_r, data_a_i, WN_r, WN_i,
                  output valid_o, out_idx, data_out_r, data_out_i);
endinterface

// File: rtl/bfu_stage16_sdf_delay_line.sv
// sdf_delay_line: DEPTH-entry shift register, head is the oldest entry
module sdf_delay_line #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (en) begin
         for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
         mem[DEPTH-1] <= din;
      end
   end
   assign head = mem[0];
endmodule

// File: rtl/bfu_stage16.sv
// bfu_stage16: first-stage radix-2 SDF butterfly, emits x[k]+x[k+16] then (x[k]-x[k+16])*W^k
module bfu_stage16
   import bfu_stage16_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   bfu_stage16_if.slave   bus
);
   logic [2*DW_O-1:0]      head, push;
   logic signed [DW_O-1:0] hr, hi, ar, ai, g_r, g_i, d_r, d_i, p_r, p_i, nxt_r, nxt_i;
   logic signed [PW-1:0]   m_r, m_i;
   logic                   first_q;
   state_t                 st;
   assign st = bus.state_i;
   assign {hr, hi} = head;
   sdf_delay_line #(.DEPTH(DEPTH), .WIDTH(2*DW_O)) u_dl (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (st != IDLE),
      .din  (push),
      .head (head)
   );
   always_comb begin
      ar = DW_O'(bus.data_a_r);
      ai = DW_O'(bus.data_a_i);
      g_r = hr + ar;
      g_i = hi + ai;
      d_r = hr - ar;
      d_i = hi - ai;
      m_r = PW'(hr) * PW'(bus.WN_r) - PW'(hi) * PW'(bus.WN_i);
      m_i = PW'(hr) * PW'(bus.WN_i) + PW'(hi) * PW'(bus.WN_r);
      p_r = sat((m_r + PW'(RND)) >>> WFRAC);
      p_i = sat((m_i + PW'(RND)) >>> WFRAC);
      // SECOND pushes zeros so the line is already empty for a back-to-back frame
      push = (st == WAITING) ? {ar, ai} : (st == FIRST) ? {d_r, d_i} : '0;
      nxt_r = (st == FIRST) ? g_r : (st == SECOND) ? p_r : '0;
      nxt_i = (st == FIRST) ? g_i : (st == SECOND) ? p_i : '0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.valid_o    <= 1'b0;
         bus.out_idx    <= '0;
         bus.data_out_r <= '0;
         bus.data_out_i <= '0;
         first_q        <= 1'b0;
      end else begin
         bus.valid_o    <= (st == FIRST) || (st == SECOND);
         bus.data_out_r <= nxt_r;
         bus.data_out_i <= nxt_i;
         first_q        <= st == FIRST;
         if (st == FIRST && !first_q) bus.out_idx <= '0;
         else if (st == FIRST || st == SECOND) bus.out_idx <= bus.out_idx + IW'(1);
      end
   end
endmodule

// File: tb/tb_bfu_stage16.sv
// tb_bfu_stage16: random and directed frames checked against an arithmetic FFT-stage model
module tb_bfu_stage16;
   import bfu_stage16_pkg::*;
   typedef struct packed {logic [4:0] idx; logic signed [8:0] r; logic signed [8:0] i;} smp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int errors = 0, checks = 0;
   int xr[32], xi[32], wr[16], wi[16];
   smp_t got_q[$], exp_q[$];
   int runs_q[$];
   int run_len = 0;
   bfu_stage16_if bus();
   bfu_stage16 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (bus.valid_o) begin
         got_q.push_back({bus.out_idx, bus.data_out_r, bus.data_out_i});
         run_len++;
      end else if (run_len > 0) begin
         runs_q.push_back(run_len);
         run_len = 0;
      end
   end
   function automatic int rnd8();
      return int'($urandom_range(255)) - 128;
   endfunction
   function automatic int clamp(input int v);
      return v > 255 ? 255 : v < -256 ? -256 : v;
   endfunction
   task automatic rand_frame();
      for (int n = 0; n < 32; n++) begin xr[n] = rnd8(); xi[n] = rnd8(); end
      for (int k = 0; k < 16; k++) begin wr[k] = rnd8(); wi[k] = rnd8(); end
   endtask
   task automatic cyc(input state_t s, input int a0, input int a1, input int w0, input int w1);
      @(negedge clk);
      bus.state_i = s;
      bus.data_a_r = 8'(a0);
      bus.data_a_i = 8'(a1);
      bus.WN_r = 8'(w0);
      bus.WN_i = 8'(w1);
   endtask
   task automatic flush();
      repeat (3) cyc(IDLE, 0, 0, 0, 0);
   endtask
   task automatic clear_q();
      got_q.delete();
      exp_q.delete();
      runs_q.delete();
   endtask
   // Drives one frame (optionally stalled mid-WAITING) and queues the model's 32 outputs
   task automatic drive_frame(input int idle_mid, input int n_sec);
      int hr, hi, pr, pi;
      for (int n = 0; n < 16; n++) begin
         if (n == 8) repeat (idle_mid) cyc(IDLE, rnd8(), rnd8(), rnd8(), rnd8());
         cyc(WAITING, xr[n], xi[n], rnd8(), rnd8());
      end
      for (int k = 0; k < 16; k++) cyc(FIRST, xr[16+k], xi[16+k], rnd8(), rnd8());
      for (int k = 0; k < n_sec; k++) cyc(SECOND, rnd8(), rnd8(), wr[k], wi[k]);
      if (n_sec == 16) begin
         for (int k = 0; k < 16; k++) exp_q.push_back({5'(k), 9'(xr[k] + xr[k+16]), 9'(xi[k] + xi[k+16])});
         for (int k = 0; k < 16; k++) begin
            hr = xr[k] - xr[k+16];
            hi = xi[k] - xi[k+16];
            pr = hr * wr[k] - hi * wi[k];
            pi = hr * wi[k] + hi * wr[k];
            exp_q.push_back({5'(16 + k), 9'(clamp((pr + 32) >>> 6)), 9'(clamp((pi + 32) >>> 6))});
         end
      end
   endtask
   task automatic test_reset();
      bus.state_i = IDLE;
      bus.data_a_r = '0; bus.data_a_i = '0; bus.WN_r = '0; bus.WN_i = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.valid_o, bus.out_idx, bus.data_out_r, bus.data_out_i} !== '0) begin
         errors++;
         $display("FAIL reset_init got v=%0b idx=%0d r=%0d i=%0d exp all 0", bus.valid_o, bus.out_idx, bus.data_out_r, bus.data_out_i);
      end
      rst_n = 1'b1;
      rand_frame();
      drive_frame(0, 5);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.valid_o, bus.out_idx, bus.data_out_r, bus.data_out_i} !== '0) begin
         errors++;
         $display("FAIL reset_async got v=%0b idx=%0d r=%0d i=%0d exp all 0", bus.valid_o, bus.out_idx, bus.data_out_r, bus.data_out_i);
      end
      bus.state_i = IDLE;
      @(negedge clk);
      #1 clear_q();
      rst_n = 1'b1;
      rand_frame();
      drive_frame(0, 16);
      flush();
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL reset_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[n]) begin
         checks++;
         if (n >= got_q.size() || got_q[n] !== exp_q[n]) begin
            errors++;
            $display("FAIL reset_out[%0d] got idx=%0d r=%0d i=%0d exp idx=%0d r=%0d i=%0d", n, got_q[n].idx, got_q[n].r, got_q[n].i, exp_q[n].idx, exp_q[n].r, exp_q[n].i);
         end
      end
   endtask
   task automatic test_ramp();
      clear_q();
      rand_frame();
      for (int n = 0; n < 32; n++) begin xr[n] = n + 1; xi[n] = 0; end
      wr[0] = 64; wi[0] = 0; wr[4] = 0; wi[4] = -64;
      drive_frame(0, 16);
      flush();
      checks++;
      if (runs_q.size() != 1 || runs_q[0] != 32) begin errors++; $display("FAIL ramp_valid runs=%0d first=%0d exp one run of 32", runs_q.size(), runs_q.size() > 0 ? runs_q[0] : 0); end
      checks++;
      if (got_q.size() != 32 || got_q[0].r !== 9'sd18 || got_q[15].r !== 9'sd48 || got_q[16].r !== -9'sd16 || got_q[16].i !== 9'sd0 || got_q[20].r !== 9'sd0 || got_q[20].i !== 9'sd16) begin
         errors++;
         $display("FAIL ramp_const got g0=%0d g15=%0d p0=(%0d,%0d) p4=(%0d,%0d) exp 18 48 (-16,0) (0,16)", got_q[0].r, got_q[15].r, got_q[16].r, got_q[16].i, got_q[20].r, got_q[20].i);
      end
      foreach (exp_q[n]) begin
         checks++;
         if (n >= got_q.size() || got_q[n] !== exp_q[n]) begin
            errors++;
            $display("FAIL ramp_out[%0d] got idx=%0d r=%0d i=%0d exp idx=%0d r=%0d i=%0d", n, got_q[n].idx, got_q[n].r, got_q[n].i, exp_q[n].idx, exp_q[n].r, exp_q[n].i);
         end
      end
   endtask
   task automatic test_impulse();
      clear_q();
      rand_frame();
      for (int n = 0; n < 32; n++) begin xr[n] = 0; xi[n] = 0; end
      xr[0] = 8; wr[0] = 64; wi[0] = 0;
      drive_frame(0, 16);
      flush();
      checks++;
      if (got_q.size() != 32 || got_q[0].r !== 9'sd8 || got_q[0].i !== 9'sd0 || got_q[16].r !== 9'sd8 || got_q[16].i !== 9'sd0) begin
         errors++;
         $display("FAIL impulse_const got o0=(%0d,%0d) o16=(%0d,%0d) exp (8,0) (8,0)", got_q[0].r, got_q[0].i, got_q[16].r, got_q[16].i);
      end
      foreach (exp_q[n]) begin
         checks++;
         if (n >= got_q.size() || got_q[n] !== exp_q[n]) begin
            errors++;
            $display("FAIL impulse_out[%0d] got idx=%0d r=%0d i=%0d exp idx=%0d r=%0d i=%0d", n, got_q[n].idx, got_q[n].r, got_q[n].i, exp_q[n].idx, exp_q[n].r, exp_q[n].i);
         end
      end
   endtask
   task automatic test_saturation();
      clear_q();
      rand_frame();
      xr[1] = 127; xi[1] = 127; xr[17] = -128; xi[17] = -128;
      wr[1] = 59; wi[1] = -25;
      drive_frame(0, 16);
      flush();
      checks++;
      if (got_q.size() != 32 || got_q[1].r !== -9'sd1 || got_q[1].i !== -9'sd1 || got_q[17].r !== 9'sd255 || got_q[17].i !== 9'sd135) begin
         errors++;
         $display("FAIL sat_const got g1=(%0d,%0d) p1=(%0d,%0d) exp (-1,-1) (255,135)", got_q[1].r, got_q[1].i, got_q[17].r, got_q[17].i);
      end
      foreach (exp_q[n]) begin
         checks++;
         if (n >= got_q.size() || got_q[n] !== exp_q[n]) begin
            errors++;
            $display("FAIL sat_out[%0d] got idx=%0d r=%0d i=%0d exp idx=%0d r=%0d i=%0d", n, got_q[n].idx, got_q[n].r, got_q[n].i, exp_q[n].idx, exp_q[n].r, exp_q[n].i);
         end
      end
   endtask
   task automatic test_back_to_back();
      clear_q();
      rand_frame();
      drive_frame(0, 16);
      rand_frame();
      drive_frame(0, 16);
      flush();
      checks++;
      if (runs_q.size() != 2 || runs_q[0] != 32 || runs_q[1] != 32) begin errors++; $display("FAIL b2b_valid runs=%0d exp two runs of 32", runs_q.size()); end
      foreach (exp_q[n]) begin
         checks++;
         if (n >= got_q.size() || got_q[n] !== exp_q[n]) begin
            errors++;
            $display("FAIL b2b_out[%0d] got idx=%0d r=%0d i=%0d exp idx=%0d r=%0d i=%0d", n, got_q[n].idx, got_q[n].r, got_q[n].i, exp_q[n].idx, exp_q[n].r, exp_q[n].i);
         end
      end
   endtask
   task automatic test_stall();
      clear_q();
      for (int c = 0; c < 5; c++) begin
         cyc(IDLE, rnd8(), rnd8(), rnd8(), rnd8());
         checks++;
         if ({bus.valid_o, bus.data_out_r, bus.data_out_i} !== '0) begin
            errors++;
            $display("FAIL stall_idle[%0d] got v=%0b r=%0d i=%0d exp 0", c, bus.valid_o, bus.data_out_r, bus.data_out_i);
         end
      end
      rand_frame();
      drive_frame(3, 16);
      flush();
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[n]) begin
         checks++;
         if (n >= got_q.size() || got_q[n] !== exp_q[n]) begin
            errors++;
            $display("FAIL stall_out[%0d] got idx=%0d r=%0d i=%0d exp idx=%0d r=%0d i=%0d", n, got_q[n].idx, got_q[n].r, got_q[n].i, exp_q[n].idx, exp_q[n].r, exp_q[n].i);
         end
      end
   endtask
   initial begin
      test_reset();
      test_ramp();
      test_impulse();
      test_saturation();
      test_back_to_back();
      test_stall();
      for (int r = 0; r < 3; r++) test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
